// File: rtl/wb_pipe_stage_if.sv
// Bus bundle for wb_pipe_stage: stage inputs, last-stage outputs and occupancy.
// Lookup signals exist only when WB_PIPE_FWD_LOOKUP_EN is defined.
interface wb_pipe_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int DEPTH  = 1
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic              in_stall;
   logic              in_hold;
   logic              in_flush;
   logic [REG_W-1:0]  in_regdest;
   logic              in_writereg;
   logic [DATA_W-1:0] in_wbvalue;
   logic              out_stall;
   logic [REG_W-1:0]  out_regdest;
   logic              out_writereg;
   logic [DATA_W-1:0] out_wbvalue;
   logic [OCC_W-1:0]  out_occupancy;
`ifdef WB_PIPE_FWD_LOOKUP_EN
   logic [REG_W-1:0]  lookup_reg;
   logic              lookup_hit;
   logic [DATA_W-1:0] lookup_value;

   modport master (
      output in_stall, in_hold, in_flush, in_regdest, in_writereg, in_wbvalue, lookup_reg,
      input  out_stall, out_regdest, out_writereg, out_wbvalue, out_occupancy,
             lookup_hit, lookup_value
   );
   modport slave (
      input  in_stall, in_hold, in_flush, in_regdest, in_writereg, in_wbvalue, lookup_reg,
      output out_stall, out_regdest, out_writereg, out_wbvalue, out_occupancy,
             lookup_hit, lookup_value
   );
`else
   modport master (
      output in_stall, in_hold, in_flush, in_regdest, in_writereg, in_wbvalue,
      input  out_stall, out_regdest, out_writereg, out_wbvalue, out_occupancy
   );
   modport slave (
      input  in_stall, in_hold, in_flush, in_regdest, in_writereg, in_wbvalue,
      output out_stall, out_regdest, out_writereg, out_wbvalue, out_occupancy
   );
`endif
endinterface

// File: rtl/wb_pipe_stage.sv
// Writeback-path register chain of DEPTH stages with hold, flush, $zero squash and occupancy.
// Define WB_PIPE_FWD_LOOKUP_EN to add the youngest-first forwarding lookup.
module wb_pipe_stage #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int DEPTH   = 1,
   parameter int ZERO_SQ = 1
) (
   input  logic           clock,
   input  logic           reset,
   wb_pipe_stage_if.slave bus
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              stall;
      logic [REG_W-1:0]  regdest;
      logic              writereg;
      logic [DATA_W-1:0] wbvalue;
   } stage_t;

   localparam stage_t BUBBLE = '{stall: 1'b1, regdest: '0, writereg: 1'b0, wbvalue: '0};

   stage_t           stage_q [DEPTH];
   stage_t           stage_d [DEPTH];
   stage_t           entry;
   logic             squash;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch can be inferred.
      stage_d = stage_q;
      occ_d   = occ_q;
      squash  = (ZERO_SQ != 0) && (bus.in_regdest == '0);
      entry   = '{stall:    1'b0,
                  regdest:  bus.in_regdest,
                  writereg: bus.in_writereg & ~squash,
                  wbvalue:  bus.in_wbvalue};
      if (bus.in_stall) entry = BUBBLE;

      if (bus.in_flush) begin
         for (int i = 0; i < DEPTH; i++) stage_d[i] = BUBBLE;
         occ_d = '0;
      end else if (!bus.in_hold) begin
         stage_d[0] = entry;
         for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
         // Count tracks one entry in and one out, so it stays equal to the writereg popcount.
         occ_d = occ_q + OCC_W'(entry.writereg) - OCC_W'(stage_q[DEPTH-1].writereg);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: the whole chain is reset because every stage becomes a visible output in turn.
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
         occ_q <= '0;
      end else begin
         // NOTE: non-blocking updates let each stage read its neighbour's pre-edge value.
         stage_q <= stage_d;
         occ_q   <= occ_d;
      end
   end

   assign bus.out_stall     = stage_q[DEPTH-1].stall;
   assign bus.out_regdest   = stage_q[DEPTH-1].regdest;
   assign bus.out_writereg  = stage_q[DEPTH-1].writereg;
   assign bus.out_wbvalue   = stage_q[DEPTH-1].wbvalue;
   assign bus.out_occupancy = occ_q;

`ifdef WB_PIPE_FWD_LOOKUP_EN
   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      bus.lookup_hit   = 1'b0;
      bus.lookup_value = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (stage_q[i].writereg && (stage_q[i].regdest == bus.lookup_reg) &&
             (bus.lookup_reg != '0)) begin
            bus.lookup_hit   = 1'b1;
            bus.lookup_value = stage_q[i].wbvalue;
         end
      end
   end
`endif
endmodule

// File: tb/tb_wb_pipe_stage.sv
// Scoreboard bench for wb_pipe_stage (DEPTH=3, ZERO_SQ=1); lookup checks need WB_PIPE_FWD_LOOKUP_EN.
module tb_wb_pipe_stage;
   localparam int DATA_W  = 32;
   localparam int REG_W   = 5;
   localparam int DEPTH   = 3;
   localparam int ZERO_SQ = 1;
   localparam int OCC_W   = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              st;
      logic [REG_W-1:0]  rd;
      logic              we;
      logic [DATA_W-1:0] val;
   } ent_t;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   ent_t exp_q[$];

   always #5 clock = ~clock;

   wb_pipe_stage_if #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) bus ();

   wb_pipe_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .ZERO_SQ(ZERO_SQ)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   function automatic ent_t mk(logic st, logic [REG_W-1:0] rd, logic we, logic [DATA_W-1:0] v);
      return {st, rd, we, v};
   endfunction

   function automatic ent_t cur_out();
      return {bus.out_stall, bus.out_regdest, bus.out_writereg, bus.out_wbvalue};
   endfunction

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Called at a negedge: drives one cycle, records the expected stage-0 entry, returns at negedge.
   task automatic cyc(logic st, logic hd, logic fl, logic [REG_W-1:0] rd, logic we,
                      logic [DATA_W-1:0] val, logic exp_we);
      bus.in_stall    = st;
      bus.in_hold     = hd;
      bus.in_flush    = fl;
      bus.in_regdest  = rd;
      bus.in_writereg = we;
      bus.in_wbvalue  = val;
      @(posedge clock);
      if (fl) begin
         exp_q.delete();
         repeat (DEPTH - 1) exp_q.push_back(mk(1'b1, '0, 1'b0, '0));
      end else if (!hd) begin
         exp_q.push_back(st ? mk(1'b1, '0, 1'b0, '0) : mk(1'b0, rd, exp_we, val));
      end
      @(negedge clock);
   endtask

   task automatic send(logic [REG_W-1:0] rd, logic we, logic [DATA_W-1:0] val, logic exp_we);
      cyc(1'b0, 1'b0, 1'b0, rd, we, val, exp_we);
   endtask

   task automatic idle(int n);
      repeat (n) send('0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_reset(int n);
      bus.in_stall = 1'b0; bus.in_hold = 1'b0; bus.in_flush = 1'b0;
      bus.in_regdest = '0; bus.in_writereg = 1'b0; bus.in_wbvalue = '0;
      reset = 1'b1;
      #1;
      check("reset_out", cur_out(), '0);
      check("reset_occ", bus.out_occupancy, '0);
      exp_q.delete();
      repeat (DEPTH - 1) exp_q.push_back('0);
      repeat (n) @(negedge clock);
      reset = 1'b0;
   endtask

   // Monitor: pops one expectation per advancing edge; checks freeze on hold, bubbles on flush.
   initial begin : monitor
      ent_t             got, e, prev;
      logic [OCC_W-1:0] prev_occ, exp_occ;
      logic             fl, hd, rs;
      prev = '0;
      prev_occ = '0;
      forever begin
         @(posedge clock);
         fl = bus.in_flush; hd = bus.in_hold; rs = reset;
         #1;
         got = cur_out();
         if (rs) begin
            // outputs held at reset value; checked by the driver
         end else if (fl) begin
            check("flush_out", got, mk(1'b1, '0, 1'b0, '0));
            check("flush_occ", bus.out_occupancy, '0);
         end else if (hd) begin
            check("hold_out", got, prev);
            check("hold_occ", bus.out_occupancy, prev_occ);
         end else if (exp_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("stream_out", got, e);
            exp_occ = OCC_W'(e.we);
            foreach (exp_q[i]) exp_occ = exp_occ + OCC_W'(exp_q[i].we);
            check("stream_occ", bus.out_occupancy, exp_occ);
         end
         prev = got;
         prev_occ = bus.out_occupancy;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : driver
`ifdef WB_PIPE_FWD_LOOKUP_EN
      bus.lookup_reg = '0;
`endif
      do_reset(2);

      // single write travels through three stages
      send(5'd5, 1'b1, 32'hDEADBEEF, 1'b1);
      idle(3);

      // one stall bubble amid back-to-back writes
      send(5'd1, 1'b1, 32'h11, 1'b1);
      send(5'd2, 1'b1, 32'h22, 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 5'd31, 1'b1, 32'hBAD, 1'b0);
      send(5'd3, 1'b1, 32'h33, 1'b1);
      send(5'd4, 1'b1, 32'h44, 1'b1);

      // full pipe frozen for four cycles, one of them also requesting a stall
      send(5'd6, 1'b1, 32'h66, 1'b1);
      send(5'd7, 1'b1, 32'h77, 1'b1);
      send(5'd8, 1'b1, 32'h88, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 32'h99, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 32'h99, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 32'h99, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 5'd9, 1'b1, 32'h99, 1'b0);
      send(5'd10, 1'b1, 32'hAA, 1'b1);
      idle(3);

      // writes to $zero keep value and regdest but lose the enable
      send(5'd0, 1'b1, 32'h7, 1'b0);
      send(5'd0, 1'b0, 32'h8, 1'b0);
      idle(3);

      // flush beats hold and stall in the same cycle
      send(5'd11, 1'b1, 32'hB1, 1'b1);
      send(5'd12, 1'b1, 32'hB2, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 5'd13, 1'b1, 32'hB3, 1'b0);
      send(5'd14, 1'b1, 32'hB4, 1'b1);
      idle(3);

      // stages: s0 rd9/2, s1 rd3/55, s2 rd9/1
      send(5'd9, 1'b1, 32'h1, 1'b1);
      send(5'd3, 1'b1, 32'h55, 1'b1);
      send(5'd9, 1'b1, 32'h2, 1'b1);
`ifdef WB_PIPE_FWD_LOOKUP_EN
      bus.lookup_reg = 5'd9; #1;
      check("lookup9_hit", bus.lookup_hit, 1'b1);
      check("lookup9_val", bus.lookup_value, 32'h2);
      bus.lookup_reg = 5'd0; #1;
      check("lookup0_hit", bus.lookup_hit, 1'b0);
      check("lookup0_val", bus.lookup_value, 32'h0);
      bus.lookup_reg = 5'd3; #1;
      check("lookup3_val", bus.lookup_value, 32'h55);
      bus.lookup_reg = 5'd4; #1;
      check("lookup4_hit", bus.lookup_hit, 1'b0);
      bus.lookup_reg = '0;
      @(negedge clock);
`endif
      // mid-stream reset clears outputs at once, first edge after release is normal
      do_reset(2);
      send(5'd15, 1'b1, 32'hC0FFEE, 1'b1);
      idle(3);

      check("sb_drained", exp_q.size(), DEPTH - 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
